// File: rtl/home_pad_tracker.sv
// Home-row scorer: detects frog arrival in the home row, fills pads, and raises
// respawn/death/score/level-clear events for the game controller.
module home_pad_tracker #(
    parameter int unsigned HOME_Y      = 40,
    parameter int unsigned PAD_W       = 24,
    parameter int unsigned PAD1_X      = 76,
    parameter int unsigned PAD2_X      = 191,
    parameter int unsigned PAD3_X      = 309,
    parameter int unsigned PAD4_X      = 425,
    parameter int unsigned PAD5_X      = 541,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       new_game,
    input  logic       frog_valid,
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    output logic [2:0] win,
    output logic       pad1,
    output logic       pad2,
    output logic       pad3,
    output logic       pad4,
    output logic       pad5,
    output logic       frog_respawn,
    output logic       death,
    output logic       score_pulse,
    output logic       level_clear,
    output logic [3:0] level
);

    localparam logic [10:0] PAD_LO [5] = '{
        11'(PAD1_X), 11'(PAD2_X), 11'(PAD3_X), 11'(PAD4_X), 11'(PAD5_X)
    };
    localparam logic [10:0] PAD_HI [5] = '{
        11'(PAD1_X + PAD_W), 11'(PAD2_X + PAD_W), 11'(PAD3_X + PAD_W),
        11'(PAD4_X + PAD_W), 11'(PAD5_X + PAD_W)
    };
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {StWatch, StHold, StClear} state_e;

    state_e     state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       in_home_q, in_home_d;
    logic [2:0] filled_q, filled_d;
    logic [4:0] pads_q, pads_d;
    logic [2:0] win_q, win_d;
    logic [3:0] level_q, level_d;
    logic       respawn_q, respawn_d;
    logic       death_q, death_d;
    logic       score_q, score_d;
    logic       lclr_q, lclr_d;

    logic       in_home;
    logic [4:0] hit;
    logic [4:0] lowest_hit;
    logic [2:0] hit_idx;
    logic       fill;

    always_comb begin
        in_home = frog_valid && (frog_y <= 10'(HOME_Y));
        for (int k = 0; k < 5; k++) begin
            hit[k] = ({1'b0, frog_x} >= PAD_LO[k]) && ({1'b0, frog_x} < PAD_HI[k]);
        end
        // Isolate the lowest set bit so the lowest-numbered pad wins.
        lowest_hit = hit & (~hit + 5'd1);
        fill       = |(lowest_hit & ~pads_q);
        hit_idx    = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (hit[k]) hit_idx = 3'(k + 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        in_home_d  = in_home;
        filled_d   = filled_q;
        pads_d     = pads_q;
        win_d      = win_q;
        level_d    = level_q;
        respawn_d  = 1'b0;
        death_d    = 1'b0;
        score_d    = 1'b0;
        lclr_d     = 1'b0;

        case (state_q)
            StWatch: begin
                if (in_home && !in_home_q) begin
                    respawn_d  = 1'b1;
                    hold_cnt_d = HOLD_INIT;
                    state_d    = StHold;
                    if (fill) begin
                        pads_d   = pads_q | lowest_hit;
                        win_d    = hit_idx;
                        filled_d = filled_q + 3'd1;
                        score_d  = 1'b1;
                    end else begin
                        death_d = 1'b1;
                        win_d   = 3'd0;
                    end
                end
            end
            StHold: begin
                if (hold_cnt_q == 4'd0) begin
                    win_d   = 3'd0;
                    state_d = (filled_q == 3'd5) ? StClear : StWatch;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            StClear: begin
                lclr_d   = 1'b1;
                pads_d   = 5'd0;
                filled_d = 3'd0;
                level_d  = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                state_d  = StWatch;
            end
            default: state_d = StWatch;
        endcase

        if (new_game) begin
            state_d    = StWatch;
            hold_cnt_d = 4'd0;
            in_home_d  = 1'b0;
            filled_d   = 3'd0;
            pads_d     = 5'd0;
            win_d      = 3'd0;
            level_d    = 4'd0;
            respawn_d  = 1'b0;
            death_d    = 1'b0;
            score_d    = 1'b0;
            lclr_d     = 1'b0;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StWatch;
            hold_cnt_q <= 4'd0;
            in_home_q  <= 1'b0;
            filled_q   <= 3'd0;
            pads_q     <= 5'd0;
            win_q      <= 3'd0;
            level_q    <= 4'd0;
            respawn_q  <= 1'b0;
            death_q    <= 1'b0;
            score_q    <= 1'b0;
            lclr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            in_home_q  <= in_home_d;
            filled_q   <= filled_d;
            pads_q     <= pads_d;
            win_q      <= win_d;
            level_q    <= level_d;
            respawn_q  <= respawn_d;
            death_q    <= death_d;
            score_q    <= score_d;
            lclr_q     <= lclr_d;
        end
    end

    assign win          = win_q;
    assign pad1         = pads_q[0];
    assign pad2         = pads_q[1];
    assign pad3         = pads_q[2];
    assign pad4         = pads_q[3];
    assign pad5         = pads_q[4];
    assign frog_respawn = respawn_q;
    assign death        = death_q;
    assign score_pulse  = score_q;
    assign level_clear  = lclr_q;
    assign level        = level_q;

endmodule
